// File: rtl/calc1_port_sched.sv
// Round-robin arbiter sharing one calc1 request port between NUM_REQ clients.
// Sequences the two-cycle calc1 request, waits (with timeout) and routes the response back.
module calc1_port_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    c_clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_cmd,
  input  logic [32*NUM_REQ-1:0]   req_op1,
  input  logic [32*NUM_REQ-1:0]   req_op2,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [1:0]              rsp_resp,
  output logic [31:0]             rsp_data,
  output logic [3:0]              calc_cmd_out,
  output logic [31:0]             calc_data_out,
  input  logic [1:0]              calc_resp_in,
  input  logic [31:0]             calc_data_in
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        tag_q, tag_d;
  logic [31:0]          op2_q, op2_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [3:0]           calc_cmd_q, calc_cmd_d;
  logic [31:0]          calc_data_q, calc_data_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_resp_q, rsp_resp_d;
  logic [31:0]          rsp_data_q, rsp_data_d;

  logic                 grant_found;
  logic [IW-1:0]        grant_idx;
  int unsigned          cand;
  logic [3:0]           sel_cmd;
  logic [31:0]          sel_op1, sel_op2;
  logic                 sel_cmd_ok;
  logic [NUM_REQ-1:0]   ready;

  // First requester at or after last_grant+1, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_q;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[IW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    sel_cmd = 4'd0;
    sel_op1 = 32'd0;
    sel_op2 = 32'd0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx == IW'(i)) begin
        sel_cmd = req_cmd[4*i +: 4];
        sel_op1 = req_op1[32*i +: 32];
        sel_op2 = req_op2[32*i +: 32];
      end
    end
  end

  assign sel_cmd_ok = (sel_cmd == 4'd1) || (sel_cmd == 4'd2) ||
                      (sel_cmd == 4'd5) || (sel_cmd == 4'd6);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    tag_d       = tag_q;
    op2_d       = op2_q;
    cnt_d       = cnt_q;
    calc_cmd_d  = 4'd0;
    calc_data_d = 32'd0;
    rsp_valid_d = '0;
    rsp_resp_d  = 2'd0;
    rsp_data_d  = 32'd0;
    ready       = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          ready  = ONE_HOT0 << grant_idx;
          last_d = grant_idx;
          tag_d  = grant_idx;
          op2_d  = sel_op2;
          if (sel_cmd_ok) begin
            state_d     = S_SEND1;
            calc_cmd_d  = sel_cmd;
            calc_data_d = sel_op1;
          end else begin
            // Rejected locally; calc1 is never touched.
            state_d     = S_DONE;
            rsp_valid_d = ONE_HOT0 << grant_idx;
            rsp_resp_d  = 2'd2;
          end
        end
      end
      S_SEND1: begin
        state_d     = S_SEND2;
        calc_data_d = op2_q;
      end
      S_SEND2: begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
      end
      S_WAIT: begin
        // A real response beats the timeout when both land in the same cycle.
        if (calc_resp_in != 2'd0) begin
          state_d     = S_DONE;
          rsp_valid_d = ONE_HOT0 << tag_q;
          rsp_resp_d  = calc_resp_in;
          rsp_data_d  = calc_data_in;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          state_d     = S_DONE;
          rsp_valid_d = ONE_HOT0 << tag_q;
          rsp_resp_d  = 2'd3;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= IW'(NUM_REQ - 1);
      tag_q       <= '0;
      op2_q       <= 32'd0;
      cnt_q       <= 8'd0;
      calc_cmd_q  <= 4'd0;
      calc_data_q <= 32'd0;
      rsp_valid_q <= '0;
      rsp_resp_q  <= 2'd0;
      rsp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      op2_q       <= op2_d;
      cnt_q       <= cnt_d;
      calc_cmd_q  <= calc_cmd_d;
      calc_data_q <= calc_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Ready is combinational, so mask it while reset holds the FSM in IDLE.
  assign req_ready     = ready & {NUM_REQ{~reset}};
  assign rsp_valid     = rsp_valid_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_data      = rsp_data_q;
  assign calc_cmd_out  = calc_cmd_q;
  assign calc_data_out = calc_data_q;

endmodule

// File: tb/tb_calc1_port_sched.sv
// Directed bench for calc1_port_sched with a small behavioural calc1 responder.
module tb_calc1_port_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 15;

  logic              c_clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_cmd;
  logic [32*NREQ-1:0] req_op1, req_op2;
  logic [NREQ-1:0]   rsp_valid;
  logic [1:0]        rsp_resp;
  logic [31:0]       rsp_data;
  logic [3:0]        calc_cmd_out;
  logic [31:0]       calc_data_out;
  logic [1:0]        calc_resp_in;
  logic [31:0]       calc_data_in;

  int n_tests = 0;
  int n_fail  = 0;
  int m_lat   = 0;

  calc1_port_sched #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .calc_cmd_out(calc_cmd_out), .calc_data_out(calc_data_out),
    .calc_resp_in(calc_resp_in), .calc_data_in(calc_data_in)
  );

  always #5 c_clk = ~c_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  // calc1 responder: answers m_lat cycles after WAIT is entered.
  initial begin
    logic [3:0]  mc;
    logic [31:0] ma, mb;
    logic [32:0] wide;
    calc_resp_in = 2'd0;
    calc_data_in = 32'd0;
    forever begin
      @(posedge c_clk); #1;
      if (calc_cmd_out != 4'd0) begin
        mc = calc_cmd_out;
        ma = calc_data_out;
        @(posedge c_clk); #1;
        mb = calc_data_out;
        repeat (m_lat + 1) begin @(posedge c_clk); #1; end
        case (mc)
          4'd1: begin
            wide = {1'b0, ma} + {1'b0, mb};
            if (wide[32]) begin calc_resp_in = 2'd2; calc_data_in = 32'd0; end
            else begin calc_resp_in = 2'd1; calc_data_in = wide[31:0]; end
          end
          4'd2: begin
            if (ma < mb) begin calc_resp_in = 2'd2; calc_data_in = 32'd0; end
            else begin calc_resp_in = 2'd1; calc_data_in = ma - mb; end
          end
          4'd5: begin calc_resp_in = 2'd1; calc_data_in = ma << mb[4:0]; end
          default: begin calc_resp_in = 2'd1; calc_data_in = ma >> mb[4:0]; end
        endcase
        @(posedge c_clk); #1;
        calc_resp_in = 2'd0;
        calc_data_in = 32'd0;
      end
    end
  end

  // One request from client c; checks calc1 drive, latency and response.
  task automatic issue(input int c, input logic [3:0] cmd, input logic [31:0] op1,
                       input logic [31:0] op2, input int lat,
                       input logic [1:0] er, input logic [31:0] ed);
    logic ok;
    int cyc, exp_lat;
    m_lat = lat;
    req_cmd[4*c +: 4]   = cmd;
    req_op1[32*c +: 32] = op1;
    req_op2[32*c +: 32] = op2;
    req_valid = NREQ'(1) << c;
    #1;
    check_eq("ready", 32'(req_ready), 32'(NREQ'(1) << c));
    step();
    req_valid = '0;
    ok = (cmd == 4'd1) || (cmd == 4'd2) || (cmd == 4'd5) || (cmd == 4'd6);
    if (ok) begin
      check_eq("send1_cmd", 32'(calc_cmd_out), 32'(cmd));
      check_eq("send1_data", calc_data_out, op1);
      step();
      check_eq("send2_cmd", 32'(calc_cmd_out), 32'd0);
      check_eq("send2_data", calc_data_out, op2);
      cyc = 2;
      exp_lat = 4 + ((lat > TMO) ? TMO : lat);
    end else begin
      check_eq("inv_calc_cmd", 32'(calc_cmd_out), 32'd0);
      cyc = 1;
      exp_lat = 1;
    end
    while (rsp_valid == '0 && cyc < 40) begin
      if (ok) check_eq("wait_calc_cmd", 32'(calc_cmd_out), 32'd0);
      step();
      cyc++;
    end
    check_eq("rsp_latency", 32'(cyc), 32'(exp_lat));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << c));
    check_eq("rsp_resp", 32'(rsp_resp), 32'(er));
    check_eq("rsp_data", rsp_data, ed);
    step();
    check_eq("rsp_pulse_end", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] seen;
    int exp_g[5];
    int cnt;
    exp_g = '{0, 1, 2, 3, 1};
    reset = 1'b1;
    req_valid = '0;
    req_cmd = '0;
    req_op1 = '0;
    req_op2 = '0;
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_calc", {calc_cmd_out, calc_data_out[27:0]}, 32'd0);
    check_eq("rst_rsp", {rsp_resp, rsp_data[29:0]}, 32'd0);
    step(); step();
    reset = 1'b0;
    step();

    issue(0, 4'd1, 32'h1, 32'h1FFF_FFFF, 1, 2'd1, 32'h2000_0000);
    issue(2, 4'd1, 32'hFFFF_FFFF, 32'h1, 2, 2'd2, 32'h0);
    issue(1, 4'd3, 32'h5, 32'h6, 0, 2'd2, 32'h0);
    issue(1, 4'd4, 32'h7, 32'h8, 0, 2'd2, 32'h0);
    issue(3, 4'd2, 32'h5, 32'h3, 20, 2'd3, 32'h0);
    seen = '0;
    repeat (6) begin
      seen |= rsp_valid | req_ready;
      step();
    end
    check_eq("late_rsp_ignored", 32'(seen), 32'd0);
    issue(0, 4'd6, 32'h80, 32'h4, TMO, 2'd1, 32'h8);
    issue(1, 4'd5, 32'h1, 32'h4, TMO - 1, 2'd1, 32'h10);
    issue(3, 4'd2, 32'd10, 32'd3, 0, 2'd1, 32'd7);

    // Contention: all four valid from reset.
    reset = 1'b1;
    m_lat = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_cmd[4*i +: 4]   = 4'd1;
      req_op1[32*i +: 32] = 32'(i);
      req_op2[32*i +: 32] = 32'd1;
    end
    req_valid = '1;
    #1;
    check_eq("rst_ready_masked", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    for (int n = 0; n < 5; n++) begin
      cnt = 0;
      while (req_ready == '0 && cnt < 30) begin step(); cnt++; end
      check_eq("rr_grant", 32'(req_ready), 32'(NREQ'(1) << exp_g[n]));
      step();
      if (n != 1) req_valid[exp_g[n]] = 1'b0;
      cnt = 0;
      while (rsp_valid == '0 && cnt < 30) begin step(); cnt++; end
      check_eq("rr_rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << exp_g[n]));
      check_eq("rr_rsp_data", rsp_data, 32'(exp_g[n] + 1));
      step();
    end

    // Reset in WAIT.
    m_lat = 5;
    req_cmd[8 +: 4]  = 4'd2;
    req_op1[64 +: 32] = 32'd10;
    req_op2[64 +: 32] = 32'd3;
    req_valid = 4'b0100;
    #1;
    check_eq("rw_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step(); step(); step();
    reset = 1'b1;
    req_cmd = '0;
    req_valid = '1;
    #1;
    check_eq("rw_ready", 32'(req_ready), 32'd0);
    check_eq("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rw_calc", {calc_cmd_out, calc_data_out[27:0]}, 32'd0);
    check_eq("rw_rsp", {rsp_resp, rsp_data[29:0]}, 32'd0);
    step(); step();
    req_valid = '0;
    reset = 1'b0;
    seen = '0;
    repeat (8) begin
      step();
      seen |= rsp_valid;
    end
    check_eq("rw_no_rsp", 32'(seen), 32'd0);
    req_valid = '1;
    #1;
    check_eq("rw_first_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    issue(0, 4'd1, 32'd2, 32'd3, 1, 2'd1, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
